// File: rtl/prog_sequencer.sv
// Multi-cycle sequencer for the 9-bit processor: FETCH/EXEC/MEM/HALT rhythm,
// Start/Done handshake, saturating performance counters and a data-memory timeout.
module prog_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             LoadInst,
    input  logic             StoreInst,
    input  logic             RegWrEn,
    input  logic             Ack,
    input  logic             BranchEn,
    input  logic             Jump,
    input  logic             BranchCond,
    input  logic             MemAck,
    output logic             PcInit,
    output logic             IrLd,
    output logic             PcInc,
    output logic             PcLoad,
    output logic             RegWe,
    output logic             MemRe,
    output logic             MemWe,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstCnt
);

    localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t            state, state_nxt;
    logic              is_load, is_load_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              err_nxt;
    logic              retire;
    logic              clr_cnt;

    always_comb begin
        state_nxt   = state;
        is_load_nxt = is_load;
        wait_nxt    = wait_cnt;
        err_nxt     = Err;
        retire      = 1'b0;
        clr_cnt     = 1'b0;
        PcInit      = 1'b0;
        IrLd        = 1'b0;
        PcInc       = 1'b0;
        PcLoad      = 1'b0;
        RegWe       = 1'b0;
        MemRe       = 1'b0;
        MemWe       = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                // gated by Reset so nothing is strobed while reset is held
                if (Start && Reset) begin
                    PcInit    = 1'b1;
                    clr_cnt   = 1'b1;
                    err_nxt   = 1'b0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                IrLd      = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (Ack) begin
                    retire    = 1'b1;
                    state_nxt = S_HALT;
                end else if (LoadInst || StoreInst) begin
                    is_load_nxt = LoadInst;
                    wait_nxt    = '0;
                    state_nxt   = S_MEM;
                end else begin
                    RegWe = RegWrEn;
                    if (Jump || (BranchEn && BranchCond)) PcLoad = 1'b1;
                    else                                  PcInc  = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                MemRe = is_load;
                MemWe = !is_load;
                if (MemAck) begin
                    RegWe     = is_load;
                    PcInc     = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign Busy = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign Done = (state == S_HALT);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            is_load  <= 1'b0;
            wait_cnt <= '0;
            Err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            is_load  <= is_load_nxt;
            wait_cnt <= wait_nxt;
            Err      <= err_nxt;
        end
    end

    // counters stick at all-ones rather than wrapping
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            CycleCnt <= '0;
            InstCnt  <= '0;
        end else if (clr_cnt) begin
            CycleCnt <= '0;
            InstCnt  <= '0;
        end else begin
            if (Busy && (CycleCnt != CNT_MAX)) CycleCnt <= CycleCnt + 1'b1;
            if (retire && (InstCnt != CNT_MAX)) InstCnt <= InstCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed program scenarios plus random stimulus,
// checked every cycle against a program-level reference model.
module tb_prog_sequencer;

    localparam int TO = 15;
    localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_MEM = 3, P_HALT = 4;

    logic Clk = 1'b0, Reset = 1'b0, Start = 1'b0;
    logic LoadInst = 1'b0, StoreInst = 1'b0, RegWrEn = 1'b0, Ack = 1'b0;
    logic BranchEn = 1'b0, Jump = 1'b0, BranchCond = 1'b0, MemAck = 1'b0;

    logic d_pcinit, d_irld, d_pcinc, d_pcload, d_regwe, d_memre, d_memwe, d_busy, d_done, d_err;
    logic [15:0] d_cyc, d_inst;
    logic s_pcinit, s_irld, s_pcinc, s_pcload, s_regwe, s_memre, s_memwe, s_busy, s_done, s_err;
    logic [3:0] s_cyc, s_inst;

    int checks = 0, failures = 0;
    int n_pcinit = 0, n_irld = 0, n_pcinc = 0, n_regwe = 0, n_memre = 0, n_memwe = 0;
    logic busy_start = 1'b0;

    // reference model: phase, 1-based count of MEM cycles entered, unbounded counters
    int ph = P_IDLE, m_memn = 0, m_cyc = 0, m_inst = 0;
    bit m_ld = 1'b0, m_err = 1'b0;

    prog_sequencer #(.CNT_W(16), .MEM_TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .LoadInst(LoadInst), .StoreInst(StoreInst),
        .RegWrEn(RegWrEn), .Ack(Ack), .BranchEn(BranchEn), .Jump(Jump), .BranchCond(BranchCond),
        .MemAck(MemAck), .PcInit(d_pcinit), .IrLd(d_irld), .PcInc(d_pcinc), .PcLoad(d_pcload),
        .RegWe(d_regwe), .MemRe(d_memre), .MemWe(d_memwe), .Busy(d_busy), .Done(d_done),
        .Err(d_err), .CycleCnt(d_cyc), .InstCnt(d_inst));

    prog_sequencer #(.CNT_W(4), .MEM_TIMEOUT(TO)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .LoadInst(LoadInst), .StoreInst(StoreInst),
        .RegWrEn(RegWrEn), .Ack(Ack), .BranchEn(BranchEn), .Jump(Jump), .BranchCond(BranchCond),
        .MemAck(MemAck), .PcInit(s_pcinit), .IrLd(s_irld), .PcInc(s_pcinc), .PcLoad(s_pcload),
        .RegWe(s_regwe), .MemRe(s_memre), .MemWe(s_memwe), .Busy(s_busy), .Done(s_done),
        .Err(s_err), .CycleCnt(s_cyc), .InstCnt(s_inst));

    initial forever #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // {PcInit,IrLd,PcInc,PcLoad,RegWe,MemRe,MemWe,Busy,Done,Err}
    function automatic logic [9:0] expect_out();
        logic [9:0] e;
        e = '0;
        e[0] = m_err;
        case (ph)
            P_IDLE: e[9] = Start && Reset;
            P_HALT: begin e[9] = Start && Reset; e[1] = 1'b1; end
            P_FETCH: begin e[8] = 1'b1; e[2] = 1'b1; end
            P_EXEC: begin
                e[2] = 1'b1;
                if (!Ack && !(LoadInst || StoreInst)) begin
                    e[5] = RegWrEn;
                    if (Jump || (BranchEn && BranchCond)) e[6] = 1'b1;
                    else e[7] = 1'b1;
                end
            end
            P_MEM: begin
                e[2] = 1'b1;
                e[4] = m_ld;
                e[3] = !m_ld;
                if (MemAck) begin e[5] = m_ld; e[7] = 1'b1; end
            end
            default: e = 'x;
        endcase
        return e;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ph <= P_IDLE; m_err <= 1'b0; m_cyc <= 0; m_inst <= 0; m_memn <= 0;
        end else begin
            if (ph == P_FETCH || ph == P_EXEC || ph == P_MEM) m_cyc <= m_cyc + 1;
            case (ph)
                P_IDLE, P_HALT:
                    if (Start) begin ph <= P_FETCH; m_cyc <= 0; m_inst <= 0; m_err <= 1'b0; end
                P_FETCH: ph <= P_EXEC;
                P_EXEC:
                    if (Ack) begin m_inst <= m_inst + 1; ph <= P_HALT; end
                    else if (LoadInst || StoreInst) begin m_ld <= LoadInst; m_memn <= 1; ph <= P_MEM; end
                    else begin m_inst <= m_inst + 1; ph <= P_FETCH; end
                P_MEM:
                    if (MemAck) begin m_inst <= m_inst + 1; ph <= P_FETCH; end
                    else if (m_memn == TO) begin ph <= P_HALT; m_err <= 1'b1; end
                    else m_memn <= m_memn + 1;
                default: ph <= P_IDLE;
            endcase
        end
    end

    always @(negedge Clk) begin
        logic [9:0] exp;
        exp = expect_out();
        chk("outputs", {d_pcinit, d_irld, d_pcinc, d_pcload, d_regwe, d_memre, d_memwe, d_busy, d_done, d_err}, exp);
        chk("outputs_w4", {s_pcinit, s_irld, s_pcinc, s_pcload, s_regwe, s_memre, s_memwe, s_busy, s_done, s_err}, exp);
        chk("cyclecnt", d_cyc, sat(m_cyc, 16));
        chk("instcnt", d_inst, sat(m_inst, 16));
        chk("cyclecnt_w4", s_cyc, sat(m_cyc, 4));
        chk("instcnt_w4", s_inst, sat(m_inst, 4));
        n_pcinit += d_pcinit; n_irld += d_irld; n_pcinc += d_pcinc;
        n_regwe += d_regwe; n_memre += d_memre; n_memwe += d_memwe;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_in(input logic st, ld, sr, we, ak, be, bc, jp, ma);
        Start = st; LoadInst = ld; StoreInst = sr; RegWrEn = we; Ack = ak;
        BranchEn = be; BranchCond = bc; Jump = jp; MemAck = ma;
    endtask

    task automatic clr_tally();
        n_pcinit = 0; n_irld = 0; n_pcinc = 0; n_regwe = 0; n_memre = 0; n_memwe = 0;
    endtask

    task automatic go();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    // flags held through FETCH as well, where they must be ignored
    task automatic alu(input logic we, be, bc, jp);
        set_in(busy_start, 0, 0, we, 0, be, bc, jp, 1);
        tick();
        tick();
    endtask

    task automatic ack_instr();
        set_in(busy_start, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic mem_instr(input logic ld, input int nwait, input logic ack);
        set_in(busy_start, ld, !ld, 1, 0, 1, 1, 1, 1);
        tick();
        set_in(busy_start, ld, !ld, 1, 0, 1, 1, 1, 0);
        tick();
        set_in(busy_start, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (nwait) tick();
        if (ack) begin
            MemAck = 1'b1;
            tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_outputs", {d_pcinit, d_irld, d_pcinc, d_pcload, d_regwe, d_memre, d_memwe, d_busy, d_done, d_err}, 10'd0);
        chk("reset_counters", {d_cyc, d_inst}, 32'd0);
        Reset = 1'b1;
        tick();

        // three ALU ops then Ack
        clr_tally();
        go();
        repeat (3) alu(1, 0, 0, 0);
        ack_instr();
        #1;
        chk("prog_done", d_done, 1);
        chk("prog_inst", d_inst, 4);
        chk("prog_cyc", d_cyc, 8);
        chk("prog_err", d_err, 0);
        chk("prog_pcinc_pulses", n_pcinc, 3);
        chk("prog_irld_pulses", n_irld, 4);
        chk("prog_pcinit_pulses", n_pcinit, 1);

        // load acked in its third MEM cycle, then store acked at once
        go();
        clr_tally();
        mem_instr(1, 2, 1);
        chk("load_back_to_fetch", d_irld, 1);
        chk("load_memre_cycles", n_memre, 3);
        chk("load_regwe", n_regwe, 1);
        chk("load_pcinc", n_pcinc, 1);
        clr_tally();
        mem_instr(0, 0, 1);
        chk("store_back_to_fetch", d_irld, 1);
        chk("store_memwe_cycles", n_memwe, 1);
        chk("store_regwe", n_regwe, 0);
        chk("store_pcinc", n_pcinc, 1);

        // branch / jump resolution, probed inside EXEC
        set_in(0, 0, 0, 0, 0, 1, 1, 0, 0); tick(); #1;
        chk("branch_taken", {d_pcload, d_pcinc}, 2'b10); tick();
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); tick(); #1;
        chk("branch_not_taken", {d_pcload, d_pcinc}, 2'b01); tick();
        set_in(0, 0, 0, 0, 0, 1, 0, 1, 0); tick(); #1;
        chk("jump", {d_pcload, d_pcinc}, 2'b10); tick();
        set_in(0, 1, 0, 0, 0, 0, 0, 1, 0); tick(); #1;
        chk("load_over_jump", {d_pcload, d_pcinc}, 2'b00); tick();
        chk("load_over_jump_mem", d_memre, 1);
        MemAck = 1'b1; tick();

        // timeout: one ALU op then a load that is never acked
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); tick(); tick();
        go();
        alu(0, 0, 0, 0);
        clr_tally();
        mem_instr(1, TO, 0);
        #1;
        chk("to_memre_cycles", n_memre, TO);
        chk("to_done_err", {d_done, d_err, d_busy}, 3'b110);
        chk("to_inst", d_inst, 1);
        chk("to_cyc", d_cyc, 4 + TO);
        go();
        chk("restart_clear", {d_err, d_cyc, d_inst}, 33'd0);

        // Start pulsed while busy is ignored
        clr_tally();
        busy_start = 1'b1;
        alu(1, 0, 0, 0);
        mem_instr(0, 1, 1);
        busy_start = 1'b0;
        chk("busy_start_pcinit", n_pcinit, 0);
        chk("busy_start_inst", d_inst, 2);

        // asynchronous reset while in MEM
        mem_instr(1, 3, 0);
        #1 Reset = 1'b0;
        #1;
        chk("midmem_reset_outputs", {d_pcinit, d_irld, d_pcinc, d_pcload, d_regwe, d_memre, d_memwe, d_busy, d_done, d_err}, 10'd0);
        chk("midmem_reset_counters", {d_cyc, d_inst}, 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        #1 Reset = 1'b1;
        tick();
        chk("after_reset_idle", {d_busy, d_done}, 2'b00);

        // 20 instruction run for counter saturation
        go();
        repeat (19) alu(1, 0, 0, 0);
        ack_instr();
        chk("sat_inst16", d_inst, 20);
        chk("sat_cyc16", d_cyc, 40);
        chk("sat_inst4", s_inst, 15);
        chk("sat_cyc4", s_cyc, 15);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int ack_mod;
            logic [3:0] op;
            ack_mod = ((i / 400) % 2 == 1) ? 25 : 2;
            op = 4'($urandom_range(0, 15));
            set_in(($urandom % 12) == 0, op < 3, op == 3 || op == 4, 1'($urandom), ($urandom % 20) == 0,
                   1'($urandom), 1'($urandom), ($urandom % 4) == 0, ($urandom % ack_mod) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Multi-cycle instruction sequencer for the 9-bit processor. It drives the fetch/execute/memory/halt rhythm around the combinational control decoder. It takes the decoder's per-instruction flags and the ALU branch condition, and produces the one-cycle strobes for the instruction register, program counter, register file and data memory. It also handles the Start/Done handshake with the test harness, performance counters and a data-memory timeout.

## Interface
- CNT_W, 16: width of CycleCnt and InstCnt.
- MEM_TIMEOUT, 15: maximum consecutive cycles spent in MEM without MemAck. Must be ≥1.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin/restart program; sampled only in IDLE or HALT.
- LoadInst, StoreInst, RegWrEn, Ack, BranchEn, Jump  in  1 each  decoder flags for the instruction currently held in the IR.
- BranchCond  in  1  ALU branch condition.
- MemAck  in  1  data memory access complete.
- PcInit  out  1  clear PC to 0.
- IrLd  out  1  latch fetched instruction.
- PcInc  out  1  PC ← PC+1.
- PcLoad  out  1  PC ← branch target.
- RegWe  out  1  register-file write strobe.
- MemRe  out  1  data-memory read request.
- MemWe  out  1  data-memory write request.
- Busy  out  1  running (FETCH/EXEC/MEM).
- Done  out  1  program halted.
- Err  out  1  halted by memory timeout.
- CycleCnt  out  CNT_W  cycles spent running.
- InstCnt  out  CNT_W  retired instructions.

## Operation
- States: IDLE, FETCH, EXEC, MEM, HALT. Reset enters IDLE. All outputs are 0 in reset and in IDLE, and the counters clear to 0.
- IDLE/HALT with Start=1: PcInit=1 that cycle, go to FETCH. Counters and Err clear on the same edge. Start=0 holds the state.
- FETCH: IrLd=1, go to EXEC.
- EXEC decides in strict priority order:
  - Ack=1: go to HALT. InstCnt +1. No PC or register strobe.
  - LoadInst or StoreInst: latch an is_load bit, clear the wait counter, go to MEM. No strobes this cycle. Branch and Jump are ignored.
  - Otherwise: RegWe=RegWrEn. If Jump or (BranchEn & BranchCond), PcLoad=1; else PcInc=1. PcLoad and PcInc are never both 1. InstCnt +1. Go to FETCH.
- MEM:
  - MemRe=is_load and MemWe=!is_load. The asserted one is held every MEM cycle.
  - MemAck=1: RegWe=is_load, PcInc=1, InstCnt +1, go to FETCH.
  - MemAck=0 with wait counter = MEM_TIMEOUT-1: go to HALT, set Err=1. No retire.
  - Otherwise: increment the wait counter and stay in MEM.
- HALT: Done=1 is held, and Err is held. PC/register/memory strobes are 0.
- Strobe outputs are a combinational function of state and inputs. Done, Busy and Err are functions of state or registered only (no input path).
- CycleCnt: +1 on every edge where the current state is FETCH, EXEC or MEM. Saturates at 2^CNT_W−1.
- InstCnt: saturates at 2^CNT_W−1.
- Inputs that are ignored:
  - Start while Busy.
  - MemAck outside MEM.
  - Decoder flags outside EXEC.

## Timing
- Non-memory instruction: 2 cycles (FETCH, EXEC).
- Memory instruction: 2 + N cycles, where N is the number of MEM cycles including the MemAck cycle. The minimum is 3.
- Timeout: exactly MEM_TIMEOUT MEM cycles, then HALT.
- Start→first IrLd: 1 cycle (Start sampled at edge k, IrLd high in cycle k+1).
- Ack instruction: Done rises in the cycle after EXEC.
- Reset asserted mid-MEM: the state returns to IDLE asynchronously. MemRe/MemWe drop immediately, with no retire and no counter update.
- Reset deassertion is synchronised externally. No output toggles until the first edge after release.

## Test plan
- Reset release then Start=1 for one cycle, program of three ALU ops then Ack:
  - PcInit=1 for one cycle.
  - IrLd every 2 cycles.
  - Three PcInc pulses.
  - Done=1 in cycle 9 after Start.
  - InstCnt=4, CycleCnt=8, Err=0.
- Load with MemAck in the 3rd MEM cycle:
  - MemRe high for 3 cycles.
  - RegWe and PcInc high only in the MemAck cycle.
  - Instruction takes 5 cycles.
- Store with immediate MemAck:
  - MemWe high 1 cycle, RegWe=0, PcInc=1.
  - Instruction takes 3 cycles.
- EXEC with BranchEn=1:
  - BranchCond=1 gives PcLoad=1, PcInc=0.
  - BranchCond=0 gives PcInc=1.
  - Jump=1 with BranchCond=0 gives PcLoad=1.
  - LoadInst=1 with Jump=1 gives MEM and no PcLoad.
- Load with MemAck never asserted, MEM_TIMEOUT=15:
  - MemRe high exactly 15 cycles, then Done=1, Err=1, and InstCnt unchanged.
  - Start then clears Err and the counters.
- Robustness:
  - Start pulsed while Busy: no effect.
  - Reset pulled low during MEM: all outputs 0 before the next edge, state IDLE.
  - CNT_W=4 with an 20-instruction run: InstCnt saturates at 15.
